// File: rtl/usb_sched_pkg.sv
// rtl/usb_sched_pkg.sv - shared constants and state encoding for the USB frame scheduler
//
// Purpose: state encoding for the scheduler FSM, the frame number width and
// the default full-speed frame timing (12 MHz bit clock, 1 ms frame).
// Ports: none (package).
package usb_sched_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SOF  = 3'd1;
  localparam state_t ST_ARB  = 3'd2;
  localparam state_t ST_BUSY = 3'd3;
  localparam state_t ST_EOF  = 3'd4;

  localparam int FRAME_NUM_W    = 11;
  localparam int DEF_FRAME_BITS = 12000;
  localparam int DEF_EOF_GUARD  = 42;

endpackage

// File: rtl/usb_rr_arbiter.sv
// rtl/usb_rr_arbiter.sv - combinational round-robin pick among eligible requesters
//
// Purpose: selects the first eligible requester at or after i_rr_ptr,
// wrapping around to index 0.
// Ports:
//   i_eligible  NUM_REQ  requesters allowed to start a transaction now
//   i_rr_ptr    PTR_W    index with highest priority this round
//   o_grant     NUM_REQ  one-hot selection (all zero when nothing eligible)
//   o_valid     1        a requester was selected
module usb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic               o_valid
);

  // Two passes: first the indices from the pointer upward, then the ones
  // below it. The first hit wins, so the grant stays one-hot.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_valid && i_eligible[i] && (i >= int'(i_rr_ptr))) begin
        o_grant[i] = 1'b1;
        o_valid    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_valid && i_eligible[i] && (i < int'(i_rr_ptr))) begin
        o_grant[i] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_frame_scheduler.sv
// rtl/usb_frame_scheduler.sv - full-speed USB host frame timer, SOF sequencer and bus arbiter
//
// Purpose: runs the frame timer in bit-time clocks, asks the packet engine
// for an SOF at every frame start and hands the bus round-robin to
// requesters whose worst-case length fits before the end-of-frame guard.
// Ports:
//   i_clk        1                bit-rate clock
//   i_reset      1                synchronous active-high reset
//   i_enable     1                scheduler run enable
//   i_req        NUM_REQ          level request per requester
//   i_req_bits   NUM_REQ*LEN_W    worst-case length of requester i at [i*LEN_W +: LEN_W]
//   i_txn_done   1                engine pulse: SOF or transaction finished
//   o_sof_req    1                engine must send SOF carrying o_frame_num
//   o_gnt        NUM_REQ          one-hot bus grant, held until i_txn_done
//   o_frame_num  11               current frame number
//   o_overrun    1                pulse: frame boundary hit while bus occupied
module usb_frame_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int FRAME_BITS = usb_sched_pkg::DEF_FRAME_BITS,
  parameter int EOF_GUARD  = usb_sched_pkg::DEF_EOF_GUARD,
  parameter int LEN_W      = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_enable,
  input  logic [NUM_REQ-1:0]                    i_req,
  input  logic [NUM_REQ*LEN_W-1:0]              i_req_bits,
  input  logic                                  i_txn_done,
  output logic                                  o_sof_req,
  output logic [NUM_REQ-1:0]                    o_gnt,
  output logic [usb_sched_pkg::FRAME_NUM_W-1:0] o_frame_num,
  output logic                                  o_overrun
);

  import usb_sched_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [LEN_W:0]   REM_MAX  = (LEN_W + 1)'(FRAME_BITS - 1);
  localparam logic [LEN_W:0]   GUARD    = (LEN_W + 1)'(EOF_GUARD);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [CNT_W-1:0]         r_frame_cnt;
  logic [FRAME_NUM_W-1:0]   r_frame_num;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic                     r_sof_pending;
  logic                     r_sof_req;
  logic [NUM_REQ-1:0]       r_gnt;
  logic                     r_overrun;

  logic                     w_wrap;
  logic                     w_occupied;
  logic [LEN_W:0]           w_remaining;
  logic [LEN_W:0]           w_room;
  logic                     w_has_room;
  logic [NUM_REQ-1:0]       w_eligible;
  logic [NUM_REQ-1:0]       w_arb_grant;
  logic                     w_arb_valid;
  logic [PTR_W-1:0]         w_ptr_nxt;
  logic                     w_sof_req_nxt;
  logic [NUM_REQ-1:0]       w_gnt_nxt;
  logic                     w_overrun_nxt;

  assign w_wrap      = (r_state != ST_IDLE) && (r_frame_cnt == CNT_LAST);
  assign w_occupied  = (r_state == ST_SOF) || (r_state == ST_BUSY);
  assign w_remaining = REM_MAX - (LEN_W + 1)'(r_frame_cnt);
  assign w_has_room  = (w_remaining >= GUARD);
  assign w_room      = w_remaining - GUARD;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = i_req[i] && w_has_room &&
                      ({1'b0, i_req_bits[i*LEN_W +: LEN_W]} <= w_room);
    end
  end

  usb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_arb_grant),
    .o_valid    (w_arb_valid)
  );

  // Next pointer sits just past the winner so it loses priority next round.
  always_comb begin
    w_ptr_nxt = r_rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) begin
        w_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. An in-flight SOF or transaction always runs to
  // i_txn_done; disable and frame wrap only act once the bus is free.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) w_next_state = ST_SOF;
      end
      ST_SOF, ST_BUSY: begin
        if (i_txn_done) begin
          if (!i_enable)                   w_next_state = ST_IDLE;
          else if (r_sof_pending || w_wrap) w_next_state = ST_SOF;
          else                             w_next_state = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!i_enable)                w_next_state = ST_IDLE;
        else if (w_wrap)              w_next_state = ST_SOF;
        else if (w_arb_valid)         w_next_state = ST_BUSY;
        else if (!w_has_room)         w_next_state = ST_EOF;
      end
      ST_EOF: begin
        if (!i_enable)   w_next_state = ST_IDLE;
        else if (w_wrap) w_next_state = ST_SOF;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    w_sof_req_nxt = (w_next_state == ST_SOF);
    w_gnt_nxt     = '0;
    if (r_state == ST_BUSY && w_next_state == ST_BUSY) begin
      w_gnt_nxt = r_gnt;
    end else if (r_state == ST_ARB && w_next_state == ST_BUSY) begin
      w_gnt_nxt = w_arb_grant;
    end
    // A boundary that lands on the very edge the bus frees up is not late.
    w_overrun_nxt = w_wrap && w_occupied && !i_txn_done;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_cnt   <= '0;
      r_frame_num   <= '0;
      r_rr_ptr      <= '0;
      r_sof_pending <= 1'b0;
      r_sof_req     <= 1'b0;
      r_gnt         <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_sof_req <= w_sof_req_nxt;
      r_gnt     <= w_gnt_nxt;
      r_overrun <= w_overrun_nxt;

      if (r_state == ST_IDLE || w_next_state == ST_IDLE || w_wrap) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end

      if (r_state == ST_SOF && i_txn_done) begin
        r_frame_num <= r_frame_num + FRAME_NUM_W'(1);
      end

      if (r_state == ST_ARB && w_next_state == ST_BUSY) begin
        r_rr_ptr <= w_ptr_nxt;
      end

      if (w_next_state == ST_IDLE || (w_occupied && i_txn_done)) begin
        r_sof_pending <= 1'b0;
      end else if (w_overrun_nxt) begin
        r_sof_pending <= 1'b1;
      end
    end
  end

  assign o_sof_req   = r_sof_req;
  assign o_gnt       = r_gnt;
  assign o_frame_num = r_frame_num;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_usb_frame_scheduler.sv
// tb/tb_usb_frame_scheduler.sv - directed self-checking bench for usb_frame_scheduler
module tb_usb_frame_scheduler;

  localparam int NR = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic [NR-1:0] i_req;
  logic [NR*LW-1:0] i_req_bits;
  logic          i_txn_done;
  logic          o_sof_req;
  logic [NR-1:0] o_gnt;
  logic [10:0]   o_frame_num;
  logic          o_overrun;

  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;

  usb_frame_scheduler #(
    .NUM_REQ    (NR),
    .FRAME_BITS (100),
    .EOF_GUARD  (10),
    .LEN_W      (LW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_req       (i_req),
    .i_req_bits  (i_req_bits),
    .i_txn_done  (i_txn_done),
    .o_sof_req   (o_sof_req),
    .o_gnt       (o_gnt),
    .o_frame_num (o_frame_num),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_overrun) ovr_cnt <= ovr_cnt + 1;

  task automatic do_reset();
    i_reset    = 1'b1;
    i_enable   = 1'b0;
    i_req      = '0;
    i_req_bits = '0;
    i_txn_done = 1'b0;
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  // Enable from IDLE and complete the first SOF 5 cycles later.
  // Returns at the negedge of F+6 where F is the first sof_req cycle.
  task automatic start_frame();
    i_enable = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    i_txn_done = 1'b1;
    @(negedge clk);
    i_txn_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_sof_req !== 1'b0) begin failures++; $display("FAIL reset_sof_req: got %0b expected 0", o_sof_req); end
    checks++; if (o_gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %04b expected 0000", o_gnt); end
    checks++; if (o_frame_num !== 11'd0) begin failures++; $display("FAIL reset_frame_num: got %0d expected 0", o_frame_num); end
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %0b expected 0", o_overrun); end
  endtask

  task automatic test_sof_period();
    int ovr0;
    do_reset();
    ovr0 = ovr_cnt;
    i_enable = 1'b1;
    @(negedge clk);
    checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL sof_first: got %0b expected 1", o_sof_req); end
    checks++; if (o_frame_num !== 11'd0) begin failures++; $display("FAIL sof_first_num: got %0d expected 0", o_frame_num); end
    repeat (5) @(negedge clk);
    i_txn_done = 1'b1;
    @(negedge clk);
    i_txn_done = 1'b0;
    checks++; if (o_sof_req !== 1'b0) begin failures++; $display("FAIL sof_drop: got %0b expected 0", o_sof_req); end
    checks++; if (o_frame_num !== 11'd1) begin failures++; $display("FAIL sof_num_inc: got %0d expected 1", o_frame_num); end
    repeat (93) @(negedge clk);
    checks++; if (o_sof_req !== 1'b0) begin failures++; $display("FAIL sof_before_wrap: got %0b expected 0", o_sof_req); end
    @(negedge clk);
    checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL sof_period: got %0b expected 1 at frame+100", o_sof_req); end
    repeat (5) @(negedge clk);
    i_txn_done = 1'b1;
    @(negedge clk);
    i_txn_done = 1'b0;
    checks++; if (o_frame_num !== 11'd2) begin failures++; $display("FAIL sof_num_second: got %0d expected 2", o_frame_num); end
    checks++; if (ovr_cnt - ovr0 !== 0) begin failures++; $display("FAIL sof_no_overrun: got %0d pulses expected 0", ovr_cnt - ovr0); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp;
    int ovr0;
    int stray;
    do_reset();
    ovr0 = ovr_cnt;
    i_req      = 4'b1111;
    i_req_bits = {16'd8, 16'd8, 16'd8, 16'd8};
    start_frame();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp = 4'b0001 << (k % 4);
      checks++; if (o_gnt !== exp) begin failures++; $display("FAIL rr_grant_%0d: got %04b expected %04b", k, o_gnt, exp); end
      repeat (8) @(negedge clk);
      i_txn_done = 1'b1;
      @(negedge clk);
      i_txn_done = 1'b0;
      checks++; if (o_gnt !== 4'b0000) begin failures++; $display("FAIL rr_release_%0d: got %04b expected 0000", k, o_gnt); end
    end
    stray = 0;
    for (int c = 87; c <= 99; c++) begin
      @(negedge clk);
      if (o_gnt !== 4'b0000) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rr_no_late_grant: got %0d granted cycles expected 0", stray); end
    @(negedge clk);
    checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL rr_next_sof: got %0b expected 1", o_sof_req); end
    checks++; if (ovr_cnt - ovr0 !== 0) begin failures++; $display("FAIL rr_no_overrun: got %0d pulses expected 0", ovr_cnt - ovr0); end
  endtask

  task automatic test_no_fit();
    int ovr0;
    int stray;
    do_reset();
    ovr0 = ovr_cnt;
    i_req = 4'b0001;
    i_req_bits[15:0] = 16'd95;
    start_frame();
    stray = 0;
    for (int c = 7; c <= 200; c++) begin
      @(negedge clk);
      i_txn_done = (c == 105);
      if (o_gnt !== 4'b0000) stray++;
      if (c == 100) begin
        checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL nofit_sof_1: got %0b expected 1", o_sof_req); end
      end
      if (c == 200) begin
        checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL nofit_sof_2: got %0b expected 1", o_sof_req); end
        checks++; if (o_frame_num !== 11'd2) begin failures++; $display("FAIL nofit_num: got %0d expected 2", o_frame_num); end
      end
    end
    i_txn_done = 1'b0;
    checks++; if (stray !== 0) begin failures++; $display("FAIL nofit_never_granted: got %0d granted cycles expected 0", stray); end
    checks++; if (ovr_cnt - ovr0 !== 0) begin failures++; $display("FAIL nofit_no_overrun: got %0d pulses expected 0", ovr_cnt - ovr0); end
  endtask

  task automatic test_overrun();
    int ovr0;
    do_reset();
    ovr0 = ovr_cnt;
    i_req = 4'b0001;
    i_req_bits[15:0] = 16'd8;
    start_frame();
    @(negedge clk);
    checks++; if (o_gnt !== 4'b0001) begin failures++; $display("FAIL ovr_grant: got %04b expected 0001", o_gnt); end
    i_req = 4'b0000;
    repeat (92) @(negedge clk);
    checks++; if (o_gnt !== 4'b0001) begin failures++; $display("FAIL ovr_gnt_held: got %04b expected 0001", o_gnt); end
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovr_pre_wrap: got %0b expected 0", o_overrun); end
    @(negedge clk);
    checks++; if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse: got %0b expected 1", o_overrun); end
    checks++; if (o_sof_req !== 1'b0) begin failures++; $display("FAIL ovr_sof_deferred: got %0b expected 0", o_sof_req); end
    @(negedge clk);
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovr_one_cycle: got %0b expected 0", o_overrun); end
    repeat (19) @(negedge clk);
    i_txn_done = 1'b1;
    @(negedge clk);
    i_txn_done = 1'b0;
    checks++; if (o_gnt !== 4'b0000) begin failures++; $display("FAIL ovr_release: got %04b expected 0000", o_gnt); end
    checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL ovr_late_sof: got %0b expected 1", o_sof_req); end
    checks++; if (o_frame_num !== 11'd1) begin failures++; $display("FAIL ovr_num_hold: got %0d expected 1", o_frame_num); end
    repeat (4) @(negedge clk);
    i_txn_done = 1'b1;
    @(negedge clk);
    i_txn_done = 1'b0;
    checks++; if (o_frame_num !== 11'd2) begin failures++; $display("FAIL ovr_num_inc: got %0d expected 2", o_frame_num); end
    checks++; if (ovr_cnt - ovr0 !== 1) begin failures++; $display("FAIL ovr_pulse_count: got %0d pulses expected 1", ovr_cnt - ovr0); end
  endtask

  task automatic test_done_at_wrap();
    int ovr0;
    do_reset();
    ovr0 = ovr_cnt;
    i_req = 4'b0001;
    i_req_bits[15:0] = 16'd8;
    start_frame();
    @(negedge clk);
    checks++; if (o_gnt !== 4'b0001) begin failures++; $display("FAIL wrapdone_grant: got %04b expected 0001", o_gnt); end
    i_req = 4'b0000;
    repeat (92) @(negedge clk);
    i_txn_done = 1'b1;
    @(negedge clk);
    i_txn_done = 1'b0;
    checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL wrapdone_sof: got %0b expected 1", o_sof_req); end
    checks++; if (o_gnt !== 4'b0000) begin failures++; $display("FAIL wrapdone_gnt: got %04b expected 0000", o_gnt); end
    checks++; if (o_overrun !== 1'b0) begin failures++; $display("FAIL wrapdone_overrun: got %0b expected 0", o_overrun); end
    @(negedge clk);
    checks++; if (ovr_cnt - ovr0 !== 0) begin failures++; $display("FAIL wrapdone_no_pulse: got %0d pulses expected 0", ovr_cnt - ovr0); end
  endtask

  task automatic test_disable();
    do_reset();
    i_req = 4'b0001;
    i_req_bits[15:0] = 16'd8;
    start_frame();
    @(negedge clk);
    checks++; if (o_gnt !== 4'b0001) begin failures++; $display("FAIL dis_grant: got %04b expected 0001", o_gnt); end
    repeat (2) @(negedge clk);
    i_enable = 1'b0;
    @(negedge clk);
    checks++; if (o_gnt !== 4'b0001) begin failures++; $display("FAIL dis_gnt_held: got %04b expected 0001", o_gnt); end
    repeat (5) @(negedge clk);
    i_txn_done = 1'b1;
    @(negedge clk);
    i_txn_done = 1'b0;
    checks++; if (o_gnt !== 4'b0000) begin failures++; $display("FAIL dis_release: got %04b expected 0000", o_gnt); end
    repeat (4) @(negedge clk);
    checks++; if ({o_sof_req, o_gnt} !== 5'b0) begin failures++; $display("FAIL dis_idle: got sof=%0b gnt=%04b expected 0/0000", o_sof_req, o_gnt); end
    checks++; if (o_frame_num !== 11'd1) begin failures++; $display("FAIL dis_num_kept: got %0d expected 1", o_frame_num); end
    i_enable = 1'b1;
    @(negedge clk);
    checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL dis_reenable_sof: got %0b expected 1", o_sof_req); end
  endtask

  task automatic test_reset_busy();
    do_reset();
    i_req = 4'b0001;
    i_req_bits[15:0] = 16'd8;
    start_frame();
    @(negedge clk);
    checks++; if (o_gnt !== 4'b0001) begin failures++; $display("FAIL rstbusy_grant: got %04b expected 0001", o_gnt); end
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    checks++; if (o_gnt !== 4'b0000) begin failures++; $display("FAIL rstbusy_gnt: got %04b expected 0000", o_gnt); end
    checks++; if (o_sof_req !== 1'b0) begin failures++; $display("FAIL rstbusy_sof: got %0b expected 0", o_sof_req); end
    checks++; if (o_frame_num !== 11'd0) begin failures++; $display("FAIL rstbusy_num: got %0d expected 0", o_frame_num); end
    i_reset = 1'b0;
    @(negedge clk);
    checks++; if (o_sof_req !== 1'b1) begin failures++; $display("FAIL rstbusy_restart: got %0b expected 1", o_sof_req); end
  endtask

  initial begin
    i_reset    = 1'b1;
    i_enable   = 1'b0;
    i_req      = '0;
    i_req_bits = '0;
    i_txn_done = 1'b0;
    test_reset();
    test_sof_period();
    test_round_robin();
    test_no_fit();
    test_overrun();
    test_done_at_wrap();
    test_disable();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
